// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// State enum, buffer entry struct, fetch widths.
package fetch_pkg;

  localparam int INSTR_W   = 32;
  localparam int PC_STEP   = 4;
  localparam int BUF_DEPTH = 2;
  localparam int PC_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MISALIGN
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry prefetch FIFO of fetch_entry_t; flush beats push.
// Ports: push/pop/flush, wdata in; head, count, full, empty out.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'(BUF_DEPTH));
  assign do_pop  = pop & ~empty;
  // A full buffer may still take a word when the head leaves.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns fetch PC, drives ROM, fills prefetch buffer.
// Ports: start/redirect control, imem_addr/imem_rd ROM, instr* to decode.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                  A_LENGTH = 12,
  parameter logic [A_LENGTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                redirect,
  input  logic [A_LENGTH-1:0] redirect_pc,
  output logic [A_LENGTH-1:0] imem_addr,
  input  logic [INSTR_W-1:0]  imem_rd,
  output logic [INSTR_W-1:0]  instr,
  output logic [A_LENGTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic                misalign_err
);

  fetch_state_e        state;
  fetch_state_e        next_state;
  logic [A_LENGTH-1:0] fpc;
  logic                aligned;
  logic                fetch_en;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [1:0]          buf_count;
  fetch_entry_t        wdata;
  fetch_entry_t        head;
  logic                unused_bits;

  assign aligned   = (redirect_pc[1:0] == 2'b00);
  assign imem_addr = fpc;
  assign pop       = instr_valid & instr_ready;
  assign push      = fetch_en & ~redirect & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
        if (redirect && !aligned) next_state = MISALIGN;
      end
      MISALIGN: begin
        if (redirect && aligned) next_state = RUN;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    fetch_en     = (state == RUN);
    misalign_err = (state == MISALIGN);
  end

  // A misaligned target leaves fpc where it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc <= RESET_PC;
    end else if (redirect) begin
      if (aligned) fpc <= redirect_pc;
    end else if (push) begin
      fpc <= fpc + A_LENGTH'(PC_STEP);
    end
  end

  assign wdata.instr = imem_rd;
  assign wdata.pc    = PC_W'(fpc);

  fetch_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .head  (head),
    .count (buf_count),
    .full  (full),
    .empty (empty)
  );

  assign instr_valid = ~empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc[A_LENGTH-1:0];
  assign unused_bits = ^{head.pc[PC_W-1:A_LENGTH], buf_count};

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a pc scoreboard.
// ROM model returns 0xA5000000 | address.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic [11:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        misalign_err;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] saved;

  always #5 clk = ~clk;

  assign imem_rd = 32'hA500_0000 | {20'h0, imem_addr};

  imem_fetch_ctrl #(
    .A_LENGTH (12),
    .RESET_PC (12'h000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_rd      (imem_rd),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .misalign_err (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input logic [11:0] base);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(base + 12'(4 * i));
  endtask

  // Called once inputs for the cycle are set: a handshake now
  // means the head is consumed at the coming edge.
  task automatic consume(input string tag);
    logic [11:0] e;
    if (instr_valid && instr_ready) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hEEE;
      chk({tag, "_pc"}, {20'h0, instr_pc}, {20'h0, e});
      chk({tag, "_instr"}, instr, 32'hA500_0000 | {20'h0, e});
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    redirect = 1'b0;
    redirect_pc = 12'h000;
    instr_ready = 1'b0;
    repeat (2) cycle();
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", {20'h0, instr_pc}, 32'h0);
    chk("rst_mis", {31'h0, misalign_err}, 32'h0);
    chk("rst_addr", {20'h0, imem_addr}, 32'h0);
    rst = 1'b0;
    repeat (3) cycle();
    chk("idle_valid", {31'h0, instr_valid}, 32'h0);
    chk("idle_addr", {20'h0, imem_addr}, 32'h0);

    // 1: start latency and streaming
    start = 1'b1;
    instr_ready = 1'b1;
    load_exp(12'h000);
    cycle();
    start = 1'b0;
    chk("t1_e1_valid", {31'h0, instr_valid}, 32'h0);
    cycle();
    chk("t1_e2_valid", {31'h0, instr_valid}, 32'h1);
    repeat (6) begin consume("t1"); cycle(); end

    // 2: backpressure saturates buffer, fpc freezes at head+8
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      saved = exp_q[0] + 12'd8;
      chk("t2_valid", {31'h0, instr_valid}, 32'h1);
      chk("t2_head", {20'h0, instr_pc}, {20'h0, exp_q[0]});
      chk("t2_addr", {20'h0, imem_addr}, {20'h0, saved});
    end
    instr_ready = 1'b1;
    repeat (6) begin consume("t2"); cycle(); end

    // 3: redirect with a pop in the same cycle
    chk("t3_pre_valid", {31'h0, instr_valid}, 32'h1);
    redirect = 1'b1;
    redirect_pc = 12'h100;
    consume("t3_pop");
    load_exp(12'h100);
    cycle();
    redirect = 1'b0;
    chk("t3_bubble", {31'h0, instr_valid}, 32'h0);
    chk("t3_addr", {20'h0, imem_addr}, 32'h100);
    cycle();
    chk("t3_valid", {31'h0, instr_valid}, 32'h1);
    repeat (4) begin consume("t3"); cycle(); end

    // 4: wrap past end of ROM window
    redirect = 1'b1;
    redirect_pc = 12'hFF8;
    consume("t4_pop");
    load_exp(12'hFF8);
    cycle();
    redirect = 1'b0;
    chk("t4_bubble", {31'h0, instr_valid}, 32'h0);
    cycle();
    repeat (5) begin consume("t4"); cycle(); end

    // 5: misaligned redirect, then recovery
    redirect = 1'b1;
    redirect_pc = 12'h102;
    consume("t5_pop");
    saved = imem_addr;
    cycle();
    redirect = 1'b0;
    chk("t5_mis", {31'h0, misalign_err}, 32'h1);
    chk("t5_valid", {31'h0, instr_valid}, 32'h0);
    chk("t5_addr", {20'h0, imem_addr}, {20'h0, saved});
    repeat (3) cycle();
    chk("t5_mis_hold", {31'h0, misalign_err}, 32'h1);
    chk("t5_valid_hold", {31'h0, instr_valid}, 32'h0);
    chk("t5_addr_hold", {20'h0, imem_addr}, {20'h0, saved});
    redirect = 1'b1;
    redirect_pc = 12'h200;
    load_exp(12'h200);
    cycle();
    redirect = 1'b0;
    chk("t5_mis_clr", {31'h0, misalign_err}, 32'h0);
    chk("t5_bubble", {31'h0, instr_valid}, 32'h0);
    cycle();
    chk("t5_valid_back", {31'h0, instr_valid}, 32'h1);
    repeat (3) begin consume("t5"); cycle(); end

    // 6: asynchronous reset between edges
    chk("t6_pre_valid", {31'h0, instr_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", {31'h0, instr_valid}, 32'h0);
    chk("t6_mis", {31'h0, misalign_err}, 32'h0);
    chk("t6_addr", {20'h0, imem_addr}, 32'h0);
    chk("t6_instr", instr, 32'h0);
    chk("t6_pc", {20'h0, instr_pc}, 32'h0);
    cycle();
    rst = 1'b0;
    repeat (4) cycle();
    chk("t6_idle_valid", {31'h0, instr_valid}, 32'h0);
    chk("t6_idle_addr", {20'h0, imem_addr}, 32'h0);
    start = 1'b1;
    load_exp(12'h000);
    cycle();
    start = 1'b0;
    chk("t6_e1_valid", {31'h0, instr_valid}, 32'h0);
    cycle();
    chk("t6_e2_valid", {31'h0, instr_valid}, 32'h1);
    repeat (3) begin consume("t6"); cycle(); end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
